reg_file_sb: RTL and testbench

//   Parametrised scoreboarded register file: two combinational read ports, one ALU write port,

---
 rtl/reg_file_sb.sv | 76 +++++++
 tb/tb_reg_file_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: scoreboarded register file, two bypassed read ports, ALU write port and a single-outstanding load return path.
// Optional hard-wired zero entry 0 via `define REG_FILE_SB_ZERO_REG_EN.
module reg_file_sb #(
  parameter int DW = 8,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          rdyA,
  output logic          rdyB,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          ld_issue,
  input  logic [PW-1:0] ld_addr,
  output logic          ld_ready,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_dat
);
  localparam int N = 2**PW;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
`ifdef REG_FILE_SB_ZERO_REG_EN
  localparam logic ZR = 1'b1;
`else
  localparam logic ZR = 1'b0;
`endif
  logic [DW-1:0] core [N];
  logic [N-1:0]  busy, busy_n;
  logic [0:0]    state;
  logic [PW-1:0] pend_addr;
  logic          cancel, issue, ld_ret, waw, ld_wr;
  logic          bwa, bla, bwb, blb;
  function automatic logic is_z(input logic [PW-1:0] a);
    return ZR && (a == '0);
  endfunction
  assign ld_ready = state == IDLE;
  assign issue    = ld_ready && ld_issue;
  assign ld_ret   = state == PENDING && ld_valid;
  // A younger ALU write to the pending destination supersedes the load.
  assign waw      = state == PENDING && wr_en && wr_addr == pend_addr;
  assign ld_wr    = ld_ret && !cancel && !waw && !is_z(pend_addr);
  always_comb begin
    busy_n = busy;
    if (ld_ret || waw) busy_n[pend_addr] = 1'b0;
    if (issue && !is_z(ld_addr)) busy_n[ld_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) core[i] <= '0;
      busy      <= '0;
      state     <= IDLE;
      pend_addr <= '0;
      cancel    <= 1'b0;
    end else begin
      busy   <= busy_n;
      state  <= issue ? PENDING : ld_ret ? IDLE : state;
      cancel <= (issue || ld_ret) ? 1'b0 : waw ? 1'b1 : cancel;
      if (issue) pend_addr <= ld_addr;
      if (ld_wr) core[pend_addr] <= ld_dat;
      if (wr_en && !is_z(wr_addr)) core[wr_addr] <= dat_in;
    end
  end
  assign bwa  = wr_en && wr_addr == rd_addrA && !is_z(rd_addrA);
  assign bla  = ld_ret && !cancel && pend_addr == rd_addrA && !is_z(rd_addrA);
  assign bwb  = wr_en && wr_addr == rd_addrB && !is_z(rd_addrB);
  assign blb  = ld_ret && !cancel && pend_addr == rd_addrB && !is_z(rd_addrB);
  assign datA_out = is_z(rd_addrA) ? '0 : bwa ? dat_in : bla ? ld_dat : core[rd_addrA];
  assign datB_out = is_z(rd_addrB) ? '0 : bwb ? dat_in : blb ? ld_dat : core[rd_addrB];
  assign rdyA = is_z(rd_addrA) || bwa || bla || !busy[rd_addrA];
  assign rdyB = is_z(rd_addrB) || bwb || blb || !busy[rd_addrB];
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table, hand-written reset/zero-reg sequences and random traffic against a transaction-level model.
module tb_reg_file_sb;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [2:0] rd_addrA = '0, rd_addrB = '0, wr_addr = '0, ld_addr = '0;
  logic [7:0] datA_out, datB_out, dat_in = '0, ld_dat = '0;
  logic       rdyA, rdyB, wr_en = 1'b0, ld_issue = 1'b0, ld_ready, ld_valid = 1'b0;
  int checks = 0, errors = 0;
`ifdef REG_FILE_SB_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  reg_file_sb #(.DW(8), .PW(3)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA_out), .datB_out(datB_out), .rdyA(rdyA), .rdyB(rdyB),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in), .ld_issue(ld_issue),
    .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_valid(ld_valid), .ld_dat(ld_dat)
  );
  always #5 clk = ~clk;
  logic [7:0] m_mem [8];
  bit         m_busy [8];
  bit         m_pend, m_cancel;
  logic [2:0] m_paddr;
  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_pend = 1'b0;
    m_cancel = 1'b0;
    m_paddr = '0;
  endtask
  task automatic m_read(input logic [2:0] a, output logic [7:0] d, output logic r);
    if (ZR && a == 3'd0) begin d = '0; r = 1'b1; end
    else if (wr_en && wr_addr == a) begin d = dat_in; r = 1'b1; end
    else if (m_pend && ld_valid && !m_cancel && m_paddr == a) begin d = ld_dat; r = 1'b1; end
    else begin d = m_mem[a]; r = !m_busy[a]; end
  endtask
  task automatic m_update();
    bit was;
    was = m_pend;
    if (was && ld_valid) begin
      if (!m_cancel && !(wr_en && wr_addr == m_paddr)) m_mem[m_paddr] = ld_dat;
      m_busy[m_paddr] = 1'b0;
      m_pend = 1'b0;
      m_cancel = 1'b0;
    end else if (!was && ld_issue) begin
      m_pend = 1'b1;
      m_paddr = ld_addr;
      m_busy[ld_addr] = !(ZR && ld_addr == 3'd0);
      m_cancel = 1'b0;
    end else if (was && wr_en && wr_addr == m_paddr) begin
      m_busy[m_paddr] = 1'b0;
      m_cancel = 1'b1;
    end
    if (wr_en) m_mem[wr_addr] = dat_in;
    if (ZR) m_mem[0] = '0;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  task automatic drive_chk(input logic we, input logic [2:0] wa, input logic [7:0] di,
                           input logic li, input logic [2:0] la, input logic lv,
                           input logic [7:0] ld, input logic [2:0] a, input logic [2:0] b);
    logic [7:0] ea, eb;
    logic ya, yb;
    @(negedge clk);
    wr_en = we; wr_addr = wa; dat_in = di; ld_issue = li; ld_addr = la;
    ld_valid = lv; ld_dat = ld; rd_addrA = a; rd_addrB = b;
    #1;
    m_read(a, ea, ya);
    m_read(b, eb, yb);
    chk("model datA", {24'd0, datA_out}, {24'd0, ea});
    chk("model rdyA", {31'd0, rdyA}, {31'd0, ya});
    chk("model datB", {24'd0, datB_out}, {24'd0, eb});
    chk("model rdyB", {31'd0, rdyB}, {31'd0, yb});
    chk("model ld_ready", {31'd0, ld_ready}, {31'd0, !m_pend});
  endtask
  task automatic tick();
    @(posedge clk);
    m_update();
  endtask
  typedef struct packed {
    logic we; logic [2:0] wa; logic [7:0] di; logic li; logic [2:0] la; logic lv; logic [7:0] ld;
    logic [2:0] ra; logic [2:0] rb; logic [7:0] ea; logic ya; logic [7:0] eb; logic yb; logic er;
  } vec_t;
  vec_t tab [18];
  initial begin
    tab[0]  = '{'1,3'd3,8'h5C,'0,3'd0,'0,8'h00,3'd3,3'd0,8'h5C,'1,8'h00,'1,'1};
    tab[1]  = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd3,3'd5,8'h5C,'1,8'h00,'1,'1};
    tab[2]  = '{'0,3'd0,8'h00,'1,3'd5,'0,8'h00,3'd3,3'd5,8'h5C,'1,8'h00,'1,'1};
    tab[3]  = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd3,3'd5,8'h5C,'1,8'h00,'0,'0};
    tab[4]  = '{'0,3'd0,8'h00,'1,3'd1,'1,8'h3E,3'd1,3'd5,8'h00,'1,8'h3E,'1,'0};
    tab[5]  = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd1,3'd5,8'h00,'1,8'h3E,'1,'1};
    tab[6]  = '{'0,3'd0,8'h00,'1,3'd2,'0,8'h00,3'd2,3'd5,8'h00,'1,8'h3E,'1,'1};
    tab[7]  = '{'1,3'd2,8'h11,'0,3'd0,'0,8'h00,3'd2,3'd2,8'h11,'1,8'h11,'1,'0};
    tab[8]  = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd2,3'd3,8'h11,'1,8'h5C,'1,'0};
    tab[9]  = '{'0,3'd0,8'h00,'0,3'd0,'1,8'hFF,3'd2,3'd0,8'h11,'1,8'h00,'1,'0};
    tab[10] = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd2,3'd5,8'h11,'1,8'h3E,'1,'1};
    tab[11] = '{'0,3'd0,8'h00,'1,3'd4,'0,8'h00,3'd4,3'd6,8'h00,'1,8'h00,'1,'1};
    tab[12] = '{'1,3'd6,8'h33,'0,3'd0,'1,8'h22,3'd4,3'd6,8'h22,'1,8'h33,'1,'0};
    tab[13] = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd4,3'd6,8'h22,'1,8'h33,'1,'1};
    tab[14] = '{'0,3'd0,8'h00,'1,3'd4,'0,8'h00,3'd4,3'd6,8'h22,'1,8'h33,'1,'1};
    tab[15] = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd4,3'd7,8'h22,'0,8'h00,'1,'0};
    tab[16] = '{'1,3'd4,8'h33,'0,3'd0,'1,8'h44,3'd4,3'd4,8'h33,'1,8'h33,'1,'0};
    tab[17] = '{'0,3'd0,8'h00,'0,3'd0,'0,8'h00,3'd4,3'd6,8'h33,'1,8'h33,'1,'1};
    m_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd_addrA = 3'(i); rd_addrB = 3'(7 - i);
      #1;
      chk("reset datA", {24'd0, datA_out}, 32'd0);
      chk("reset rdyB", {31'd0, rdyB}, 32'd1);
    end
    chk("reset ld_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      drive_chk(tab[k].we, tab[k].wa, tab[k].di, tab[k].li, tab[k].la, tab[k].lv, tab[k].ld, tab[k].ra, tab[k].rb);
      chk($sformatf("vec%0d datA", k), {24'd0, datA_out}, {24'd0, tab[k].ea});
      chk($sformatf("vec%0d rdyA", k), {31'd0, rdyA}, {31'd0, tab[k].ya});
      chk($sformatf("vec%0d datB", k), {24'd0, datB_out}, {24'd0, tab[k].eb});
      chk($sformatf("vec%0d rdyB", k), {31'd0, rdyB}, {31'd0, tab[k].yb});
      chk($sformatf("vec%0d ld_ready", k), {31'd0, ld_ready}, {31'd0, tab[k].er});
      tick();
    end
    for (int k = 0; k < 600; k++) begin
      drive_chk($urandom_range(0, 2) == 0, 3'($urandom), 8'($urandom), $urandom_range(0, 1) == 1,
                3'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom), 3'($urandom));
      tick();
    end
    drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '1, 8'h00, 3'd0, 3'd0);
    tick();
    drive_chk('0, 3'd0, 8'h00, '1, 3'd7, '0, 8'h00, 3'd7, 3'd7);
    tick();
    drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '0, 8'h00, 3'd7, 3'd7);
    chk("pending rdyA", {31'd0, rdyA}, 32'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addrA = 3'(i); rd_addrB = 3'(i);
      #1;
      chk("midload reset datA", {24'd0, datA_out}, 32'd0);
      chk("midload reset rdyA", {31'd0, rdyA}, 32'd1);
      chk("midload reset rdyB", {31'd0, rdyB}, 32'd1);
      chk("midload reset ld_ready", {31'd0, ld_ready}, 32'd1);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '1, 8'hAA, 3'd7, 3'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '0, 8'h00, 3'(i), 3'(7 - i));
      chk("post reset datA", {24'd0, datA_out}, 32'd0);
      chk("post reset datB", {24'd0, datB_out}, 32'd0);
      tick();
    end
`ifdef REG_FILE_SB_ZERO_REG_EN
    drive_chk('1, 3'd0, 8'h77, '1, 3'd0, '0, 8'h00, 3'd0, 3'd0);
    chk("zero bypass datA", {24'd0, datA_out}, 32'd0);
    chk("zero bypass rdyA", {31'd0, rdyA}, 32'd1);
    tick();
    drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '1, 8'h55, 3'd0, 3'd0);
    chk("zero pending rdyA", {31'd0, rdyA}, 32'd1);
    chk("zero return datA", {24'd0, datA_out}, 32'd0);
    tick();
    drive_chk('0, 3'd0, 8'h00, '0, 3'd0, '0, 8'h00, 3'd0, 3'd0);
    chk("zero stored datA", {24'd0, datA_out}, 32'd0);
    tick();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
